// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
// Data port wins arbitration unless fetch has been passed over FETCH_STARVE times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int FETCH_STARVE = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              err
);

  localparam int SC_W = (FETCH_STARVE > 0) ? $clog2(FETCH_STARVE + 1) : 1;
  localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(FETCH_STARVE);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(MAX_WAIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]      state;
  logic            gnt_dm;
  logic [SC_W-1:0] starve_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic            pick_dm;
  logic            pick_if;
  logic            timeout;
  logic            finish;

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  always_comb begin
    pick_dm = 1'b0;
    pick_if = 1'b0;
    if (dm_req && !(if_req && starve_cnt == STARVE_MAX)) begin
      pick_dm = 1'b1;
    end else if (if_req) begin
      pick_if = 1'b1;
    end
  end

  // An access ends either with memory completion or after MAX_WAIT unanswered cycles.
  assign timeout = (state == S_ISSUE) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign finish  = (state == S_ISSUE) && (mem_ready || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gnt_dm     <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_dm || pick_if) begin
            gnt_dm    <= pick_dm;
            mem_req   <= 1'b1;
            mem_we    <= pick_dm & dm_we;
            mem_addr  <= pick_dm ? dm_addr : if_addr;
            mem_wdata <= pick_dm ? dm_wdata : '0;
            wait_cnt  <= '0;
            state     <= S_ISSUE;
            if (pick_if) begin
              starve_cnt <= '0;
            end else if (if_req && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (!mem_ready) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
          if (finish) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (timeout) begin
              err <= 1'b1;
            end
            // Stores and timed-out accesses return zero data.
            if (gnt_dm) begin
              dm_ack   <= 1'b1;
              dm_rdata <= (timeout || mem_we) ? '0 : mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= timeout ? '0 : mem_rdata;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed scenario tasks followed by randomized traffic against a queue-free reference model.
module tb_mem_port_arbiter;

  localparam int FS = 4;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_if;
  logic        stall_dm;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int ready_delay = 0;
  bit rand_delay = 1'b0;
  int issue_cycles = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FETCH_STARVE(FS), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_dm(stall_dm), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory responder: answers after ready_delay cycles of an outstanding request.
  always @(negedge clk) begin
    if (mem_req) begin
      if (issue_cycles == 0 && rand_delay) ready_delay = $urandom_range(0, 4);
      if (issue_cycles == ready_delay) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      issue_cycles++;
    end else begin
      mem_ready = 1'b0;
      issue_cycles = 0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, if_ack, dm_ack, err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, if_ack, dm_ack, err}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, dm_rdata); end
    checks++; if (stall_if !== 1'b1 || stall_dm !== 1'b0) begin errors++; $display("FAIL reset_stall got %b%b exp 10", stall_if, stall_dm); end
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    mem_arr[32'h40] = 32'hDEAD_BEEF;
    ready_delay = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_dm !== 1'b1) begin errors++; $display("FAIL load_c0 got req=%b stall=%b exp 0 1", mem_req, stall_dm); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || stall_dm !== 1'b1) begin errors++; $display("FAIL load_c1 got req=%b addr=%h we=%b stall=%b exp 1 40 0 1", mem_req, mem_addr, mem_we, stall_dm); end
    @(negedge clk);
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0 || stall_dm !== 1'b0) begin errors++; $display("FAIL load_c2 got ack=%b rdata=%h req=%b stall=%b exp 1 deadbeef 0 0", dm_ack, dm_rdata, mem_req, stall_dm); end
    dm_req = 1'b0;
    @(negedge clk);
    checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL load_c3 got ack=%b req=%b exp 0 0", dm_ack, mem_req); end
  endtask

  task automatic test_simultaneous();
    ready_delay = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234;
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL sim_c0 got req=%b stall_if=%b exp 0 1", mem_req, stall_if); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h1234 || stall_if !== 1'b1) begin errors++; $display("FAIL sim_store_issue got req=%b we=%b addr=%h wd=%h exp 1 1 80 1234", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if (dm_ack !== 1'b1 || if_ack !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL sim_dm_ack got dm_ack=%b if_ack=%b stall_if=%b exp 1 0 1", dm_ack, if_ack, stall_if); end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL sim_c3 got req=%b stall_if=%b exp 0 1", mem_req, stall_if); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h80 || stall_if !== 1'b1) begin errors++; $display("FAIL sim_fetch_issue got req=%b we=%b addr=%h exp 1 0 80", mem_req, mem_we, mem_addr); end
    @(negedge clk);
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234 || stall_if !== 1'b0) begin errors++; $display("FAIL sim_if_ack got ack=%b rdata=%h stall=%b exp 1 1234 0", if_ack, if_rdata, stall_if); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int m_st = 0;
    int grants = 0;
    bit prev = 1'b0;
    bit exp_dm;
    bit got_dm;
    bit done = 1'b0;
    ready_delay = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        grants++;
        exp_dm = (m_st != FS);
        if (exp_dm) m_st = (m_st < FS) ? m_st + 1 : m_st;
        else m_st = 0;
        got_dm = (mem_addr == 32'h200);
        checks++; if (got_dm !== exp_dm) begin errors++; $display("FAIL starve_grant%0d got dm=%b exp dm=%b", grants, got_dm, exp_dm); end
        if (grants == 5) begin
          checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL starve_fifth_if got addr=%h exp 300", mem_addr); end
        end
      end
      prev = mem_req;
      if (grants == 10 && (if_ack || dm_ack)) begin
        if_req = 1'b0; dm_req = 1'b0; done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL starve_timeout got grants=%0d exp 10", grants); end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    ready_delay = 5;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h48 || mem_we !== 1'b0 || dm_ack !== 1'b0) begin errors++; $display("FAIL wait_issue_c%0d got req=%b addr=%h we=%b ack=%b exp 1 48 0 0", c, mem_req, mem_addr, mem_we, dm_ack); end
    end
    @(negedge clk);
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== dflt(32'h48)) begin errors++; $display("FAIL wait_ack got ack=%b rdata=%h exp 1 %h", dm_ack, dm_rdata, dflt(32'h48)); end
    dm_req = 1'b0;
    @(negedge clk);
    checks++; if (dm_ack !== 1'b0) begin errors++; $display("FAIL wait_ack_pulse got %b exp 0", dm_ack); end
    ready_delay = 0;
  endtask

  task automatic test_timeout();
    ready_delay = 1000;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    @(negedge clk);
    for (int c = 1; c <= MW; c++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || err !== 1'b0 || dm_ack !== 1'b0) begin errors++; $display("FAIL tmo_issue_c%0d got req=%b err=%b ack=%b exp 1 0 0", c, mem_req, err, dm_ack); end
    end
    @(negedge clk);
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0 || err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL tmo_resp got ack=%b rdata=%h err=%b req=%b exp 1 0 1 0", dm_ack, dm_rdata, err, mem_req); end
    dm_req = 1'b0;
    ready_delay = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    repeat (3) @(negedge clk);
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234 || err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got ack=%b rdata=%h err=%b exp 1 1234 1", if_ack, if_rdata, err); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ready_delay = 1000;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4C;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || err !== 1'b0 || dm_ack !== 1'b0 || stall_dm !== 1'b1) begin errors++; $display("FAIL rstmid_now got req=%b err=%b ack=%b stall=%b exp 0 0 0 1", mem_req, err, dm_ack, stall_dm); end
    dm_req = 1'b0;
    @(negedge clk);
    checks++; if (dm_ack !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_hold got ack=%b addr=%h exp 0 0", dm_ack, mem_addr); end
    rst_n = 1'b1;
    ready_delay = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL rstmid_refetch got req=%b addr=%h exp 1 80", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234) begin errors++; $display("FAIL rstmid_fetch got ack=%b rdata=%h exp 1 1234", if_ack, if_rdata); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int m_st = 0;
    int if_wait = 0;
    int dm_wait = 0;
    bit prev = 1'b0;
    bit cur_dm = 1'b0;
    bit exp_dm;
    logic [31:0] e_addr;
    rand_delay = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        exp_dm = dm_req && !(if_req && m_st == FS);
        e_addr = exp_dm ? dm_addr : if_addr;
        checks++; if (mem_addr !== e_addr || mem_we !== (exp_dm & dm_we) || (exp_dm && dm_we && mem_wdata !== dm_wdata)) begin errors++; $display("FAIL rnd_grant got addr=%h we=%b exp addr=%h we=%b", mem_addr, mem_we, e_addr, exp_dm & dm_we); end
        if (exp_dm) begin
          if (if_req && m_st < FS) m_st++;
        end else begin
          m_st = 0;
        end
        cur_dm = exp_dm;
      end
      prev = mem_req;
      if (if_req) if_wait++;
      if (dm_req) dm_wait++;
      if (if_ack) begin
        checks++; if (cur_dm !== 1'b0 || if_rdata !== ref_rd(if_addr) || if_wait > 60) begin errors++; $display("FAIL rnd_if_ack got rdata=%h wait=%0d exp %h", if_rdata, if_wait, ref_rd(if_addr)); end
        if_req = 1'b0;
      end
      if (dm_ack) begin
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        checks++; if (cur_dm !== 1'b1 || dm_rdata !== (dm_we ? 32'h0 : ref_rd(dm_addr)) || dm_wait > 60) begin errors++; $display("FAIL rnd_dm_ack got rdata=%h wait=%0d exp %h", dm_rdata, dm_wait, dm_we ? 32'h0 : ref_rd(dm_addr)); end
        dm_req = 1'b0;
      end
      if (cyc < 900) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 32'h1000 | $urandom_range(0, 31); if_wait = 0;
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = 32'h1000 | $urandom_range(0, 31);
          dm_wdata = $urandom; dm_wait = 0;
        end
      end else if (!if_req && !dm_req && !mem_req) begin
        break;
      end
    end
    checks++; if (if_req || dm_req || err !== 1'b0) begin errors++; $display("FAIL rnd_drain got if=%b dm=%b err=%b exp 0 0 0", if_req, dm_req, err); end
    rand_delay = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
